// File: rtl/ysyx_lsu_resp_if.sv
// Memory-side bus between the LSU and the data memory: one request channel
// with a valid/ready handshake and a response channel that is always accepted.
interface ysyx_lsu_resp_if #(
    parameter int BIT_W = 32
);
    logic             bus_req_valid;
    logic             bus_req_ready;
    logic             bus_wen;
    logic [BIT_W-1:0] bus_addr;
    logic [BIT_W-1:0] bus_wdata;
    logic [3:0]       bus_wstrb;
    logic             bus_rsp_valid;
    logic [BIT_W-1:0] bus_rdata;
    logic             bus_rsp_err;

    modport master (
        output bus_req_valid, bus_wen, bus_addr, bus_wdata, bus_wstrb,
        input  bus_req_ready, bus_rsp_valid, bus_rdata, bus_rsp_err
    );

    modport slave (
        input  bus_req_valid, bus_wen, bus_addr, bus_wdata, bus_wstrb,
        output bus_req_ready, bus_rsp_valid, bus_rdata, bus_rsp_err
    );
endinterface

// File: rtl/ysyx_lsu_resp.sv
// Load/store unit bus sequencer: aligns store data and strobes onto a word bus,
// waits for one response, and returns extended load data with a one-cycle done pulse.
module ysyx_lsu_resp #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsu_avalid,
    input  logic             ren,
    input  logic             wen,
    input  logic [BIT_W-1:0] rwaddr,
    input  logic [3:0]       alu_op,
    input  logic [BIT_W-1:0] lsu_mem_wdata,
    output logic [BIT_W-1:0] lsu_rdata,
    output logic             lsu_exu_rvalid,
    output logic             lsu_exu_wready,
    output logic             lsu_err_o,
    ysyx_lsu_resp_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [BIT_W-1:0] addr_q;
    logic [1:0]       size_q;
    logic             unsigned_q;
    logic [BIT_W-1:0] wdata_q;
    logic             is_load_q;
    logic             err_q;

    logic             start;
    logic             misaligned;
    logic [BIT_W-1:0] rsp_shift;
    logic [BIT_W-1:0] rsp_ext;

    // alu_op[3] carries no meaning for memory accesses
    logic unused_op;
    assign unused_op = alu_op[3];

    assign start = lsu_avalid & (ren | wen);

    always_comb begin
        misaligned = 1'b0;
        case (alu_op[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = rwaddr[0];
            2'b10:   misaligned = (rwaddr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus.bus_req_ready) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (bus.bus_rsp_valid) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend to the full width
    always_comb begin
        rsp_shift = bus.bus_rdata >> {addr_q[1:0], 3'b000};
        rsp_ext   = rsp_shift;
        case (size_q)
            2'b00: rsp_ext = unsigned_q ? {{(BIT_W-8){1'b0}}, rsp_shift[7:0]}
                                        : {{(BIT_W-8){rsp_shift[7]}}, rsp_shift[7:0]};
            2'b01: rsp_ext = unsigned_q ? {{(BIT_W-16){1'b0}}, rsp_shift[15:0]}
                                        : {{(BIT_W-16){rsp_shift[15]}}, rsp_shift[15:0]};
            default: rsp_ext = rsp_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q     <= '0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            is_load_q  <= 1'b0;
            err_q      <= 1'b0;
            lsu_rdata  <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                addr_q     <= rwaddr;
                size_q     <= alu_op[1:0];
                unsigned_q <= alu_op[2];
                wdata_q    <= lsu_mem_wdata;
                is_load_q  <= ren;
                err_q      <= misaligned;
                if (misaligned) begin
                    lsu_rdata <= '0;
                end
            end
            if (state_q == RSP && bus.bus_rsp_valid) begin
                err_q     <= bus.bus_rsp_err;
                lsu_rdata <= (is_load_q && !bus.bus_rsp_err) ? rsp_ext : '0;
            end
        end
    end

    // Payload is built purely from captured state, so it cannot move while waiting for ready
    always_comb begin
        bus.bus_wstrb = 4'b0000;
        if (!is_load_q) begin
            case (size_q)
                2'b00:   bus.bus_wstrb = 4'b0001 << addr_q[1:0];
                2'b01:   bus.bus_wstrb = 4'b0011 << addr_q[1:0];
                default: bus.bus_wstrb = 4'b1111;
            endcase
        end
    end

    assign bus.bus_req_valid = (state_q == REQ);
    assign bus.bus_wen       = ~is_load_q;
    assign bus.bus_addr      = {addr_q[BIT_W-1:2], 2'b00};
    assign bus.bus_wdata     = wdata_q << {addr_q[1:0], 3'b000};

    assign lsu_exu_rvalid = (state_q == DONE) &  is_load_q;
    assign lsu_exu_wready = (state_q == DONE) & ~is_load_q;
    assign lsu_err_o      = (state_q == DONE) &  err_q;

endmodule

// File: tb/tb_ysyx_lsu_resp.sv
// Randomized bench for ysyx_lsu_resp: every transaction is predicted from the
// access size, byte offset and sign rule with plain arithmetic, then checked cycle by cycle.
module tb_ysyx_lsu_resp;

    logic        clk;
    logic        rst;
    logic        lsu_avalid;
    logic        ren;
    logic        wen;
    logic [31:0] rwaddr;
    logic [3:0]  alu_op;
    logic [31:0] lsu_mem_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_exu_rvalid;
    logic        lsu_exu_wready;
    logic        lsu_err_o;

    int checks = 0;
    int errors = 0;

    ysyx_lsu_resp_if #(.BIT_W(32)) bus ();

    ysyx_lsu_resp #(.BIT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_avalid     (lsu_avalid),
        .ren            (ren),
        .wen            (wen),
        .rwaddr         (rwaddr),
        .alu_op         (alu_op),
        .lsu_mem_wdata  (lsu_mem_wdata),
        .lsu_rdata      (lsu_rdata),
        .lsu_exu_rvalid (lsu_exu_rvalid),
        .lsu_exu_wready (lsu_exu_wready),
        .lsu_err_o      (lsu_err_o),
        .bus            (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected load value: select the addressed bytes, then apply the sign rule arithmetically
    function automatic logic [31:0] expLoad(input logic [31:0] rdata, input logic [3:0] op, input int a);
        logic [31:0] v;
        v = rdata >> (8 * a);
        case (op[1:0])
            2'b00: begin
                v = v % 256;
                if (!op[2] && v >= 128) v = v - 256;
            end
            2'b01: begin
                v = v % 65536;
                if (!op[2] && v >= 32768) v = v - 65536;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic checkIdleQuiet(input string tag, input logic [31:0] hold);
        checkOutput({tag, "_req_valid"}, bus.bus_req_valid, 0);
        checkOutput({tag, "_rvalid"}, lsu_exu_rvalid, 0);
        checkOutput({tag, "_wready"}, lsu_exu_wready, 0);
        checkOutput({tag, "_err"}, lsu_err_o, 0);
        checkOutput({tag, "_rdata"}, lsu_rdata, hold);
    endtask

    // Runs one full access, starting just after a clock edge with the DUT idle
    task automatic applyStimulus(input bit is_load, input bit both, input logic [31:0] addr,
                                 input logic [3:0] op, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input bit rerr,
                                 input int rdy_dly, input int rsp_dly);
        int          a;
        int          nbytes;
        bit          mis;
        logic [31:0] exp_addr;
        logic [31:0] exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        bit          exp_err;

        a         = int'(addr % 4);
        nbytes    = 1 << op[1:0];
        mis       = (op[1:0] == 2'b11) || ((a % nbytes) != 0);
        exp_addr  = addr - a;
        exp_strb  = is_load ? 0 : (((1 << nbytes) - 1) << a);
        exp_wdata = wdata << (8 * a);
        exp_err   = mis || rerr;
        exp_rd    = (mis || !is_load || rerr) ? 0 : expLoad(rdata, op, a);

        lsu_avalid    = 1'b1;
        ren           = is_load;
        wen           = !is_load || both;
        rwaddr        = addr;
        alu_op        = op;
        lsu_mem_wdata = wdata;
        checkOutput("idle_req_valid", bus.bus_req_valid, 0);
        step();

        if (!mis) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                bus.bus_req_ready = (i == rdy_dly);
                bus.bus_rsp_valid = 1'($urandom % 2);
                bus.bus_rdata     = $urandom;
                bus.bus_rsp_err   = 1'($urandom % 2);
                checkOutput("req_valid", bus.bus_req_valid, 1);
                checkOutput("req_addr", bus.bus_addr, exp_addr);
                checkOutput("req_wen", bus.bus_wen, !is_load);
                checkOutput("req_wstrb", bus.bus_wstrb, exp_strb);
                if (!is_load) checkOutput("req_wdata", bus.bus_wdata, exp_wdata);
                checkOutput("req_done", lsu_exu_rvalid | lsu_exu_wready, 0);
                step();
            end
            bus.bus_req_ready = 1'b0;
            for (int j = 0; j <= rsp_dly; j++) begin
                bus.bus_rsp_valid = (j == rsp_dly);
                bus.bus_rdata     = (j == rsp_dly) ? rdata : $urandom;
                bus.bus_rsp_err   = (j == rsp_dly) ? rerr : 1'b0;
                checkOutput("rsp_req_valid", bus.bus_req_valid, 0);
                checkOutput("rsp_done", lsu_exu_rvalid | lsu_exu_wready, 0);
                step();
            end
            bus.bus_rsp_valid = 1'b0;
        end

        checkOutput("done_rvalid", lsu_exu_rvalid, is_load);
        checkOutput("done_wready", lsu_exu_wready, !is_load);
        checkOutput("done_err", lsu_err_o, exp_err);
        checkOutput("done_rdata", lsu_rdata, exp_rd);
        checkOutput("done_req_valid", bus.bus_req_valid, 0);
        lsu_avalid = 1'($urandom % 2);
        step();

        checkIdleQuiet("after", exp_rd);
        lsu_avalid        = 1'b0;
        ren               = 1'b0;
        wen               = 1'b0;
        bus.bus_rsp_valid = 1'($urandom % 2);
        bus.bus_rdata     = $urandom;
        step();
        checkIdleQuiet("stray", exp_rd);
        bus.bus_rsp_valid = 1'b0;
    endtask

    initial begin
        rst               = 1'b0;
        lsu_avalid        = 1'b0;
        ren               = 1'b0;
        wen               = 1'b0;
        rwaddr            = '0;
        alu_op            = '0;
        lsu_mem_wdata     = '0;
        bus.bus_req_ready = 1'b0;
        bus.bus_rsp_valid = 1'b0;
        bus.bus_rdata     = '0;
        bus.bus_rsp_err   = 1'b0;
        step();
        step();
        checkIdleQuiet("reset", 0);
        rst = 1'b1;
        step();

        $display("[TB] directed accesses");
        applyStimulus(1, 0, 32'h8000_0003, 4'b0000, 32'h0, 32'h80FF_1234, 0, 0, 0);
        applyStimulus(1, 1, 32'h8000_0002, 4'b0101, 32'h0, 32'h9ABC_0000, 0, 1, 2);
        applyStimulus(0, 0, 32'h8000_0002, 4'b0001, 32'h0000_BEEF, 32'h1234_5678, 0, 3, 0);
        applyStimulus(1, 0, 32'h8000_0001, 4'b0010, 32'h0, 32'hFFFF_FFFF, 0, 0, 0);
        applyStimulus(0, 0, 32'h8000_0004, 4'b0010, 32'hCAFE_F00D, 32'h0, 1, 0, 1);
        applyStimulus(1, 0, 32'h8000_0001, 4'b0011, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 32'h8000_0006, 4'b0001, 32'h0, 32'h8001_0000, 0, 0, 0);

        $display("[TB] reset during RSP");
        lsu_avalid = 1'b1;
        ren        = 1'b1;
        wen        = 1'b0;
        rwaddr     = 32'h8000_0000;
        alu_op     = 4'b0010;
        step();
        bus.bus_req_ready = 1'b1;
        step();
        bus.bus_req_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        lsu_avalid = 1'b0;
        ren        = 1'b0;
        checkIdleQuiet("rst_rsp", 0);
        bus.bus_rsp_valid = 1'b1;
        bus.bus_rdata     = 32'h5555_AAAA;
        step();
        bus.bus_rsp_valid = 1'b0;
        checkIdleQuiet("rst_stray", 0);
        step();
        checkIdleQuiet("rst_stray2", 0);

        $display("[TB] reset during REQ");
        applyStimulus(1, 0, 32'h8000_0008, 4'b0010, 32'h0, 32'h1357_9BDF, 0, 0, 0);
        lsu_avalid = 1'b1;
        wen        = 1'b1;
        rwaddr     = 32'h8000_000C;
        alu_op     = 4'b0010;
        step();
        checkOutput("mid_req_valid", bus.bus_req_valid, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        lsu_avalid = 1'b0;
        wen        = 1'b0;
        checkIdleQuiet("rst_req", 0);
        bus.bus_req_ready = 1'b1;
        step();
        bus.bus_req_ready = 1'b0;
        checkIdleQuiet("rst_req2", 0);

        $display("[TB] random accesses");
        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            op = 4'($urandom);
            if ($urandom % 4 != 0 && op[1:0] == 2'b11) op[1:0] = 2'b10;
            applyStimulus(1'($urandom % 2), 1'($urandom % 2),
                          32'h8000_0000 | ($urandom & 32'h0000_FFFF), op,
                          $urandom, $urandom, ($urandom % 8 == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_lsu_resp.md
YSYX_LSU_RESP -- requirements
Module: ysyx_lsu_resp

Interface
REQ-001 SHALL have parameter BIT_W, default 32, data/address width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have lsu_avalid  input  1  request valid from execute stage, held until response.
REQ-005 SHALL have ren  input  1  load request.
REQ-006 SHALL have wen  input  1  store request.
REQ-007 SHALL have rwaddr  input  BIT_W  byte address.
REQ-008 SHALL have alu_op  input  4  bits[1:0] size (00 byte, 01 half, 10 word), bit[2] unsigned load, bit[3] ignored.
REQ-009 SHALL have lsu_mem_wdata  input  BIT_W  store data, right-aligned.
REQ-010 SHALL have lsu_rdata  output  BIT_W  aligned, extended load data.
REQ-011 SHALL have lsu_exu_rvalid  output  1  load-done pulse.
REQ-012 SHALL have lsu_exu_wready  output  1  store-done pulse.
REQ-013 SHALL have lsu_err_o  output  1  error pulse, coincident with the done pulse.
REQ-014 SHALL have bus_req_valid  output  1, bus_req_ready  input  1  request handshake.
REQ-015 SHALL have bus_wen  output  1, bus_addr  output  BIT_W, bus_wdata  output  BIT_W, bus_wstrb  output  4  request payload.
REQ-016 SHALL have bus_rsp_valid  input  1, bus_rdata  input  BIT_W, bus_rsp_err  input  1  response; always accepted.

Function
REQ-017 SHALL implement FSM IDLE, REQ, RSP, DONE.
REQ-018 IDLE: on lsu_avalid & (ren|wen), SHALL capture addr, alu_op, wdata, and type, then enter REQ; ren has priority when both are set.
REQ-019 IDLE capture SHALL detect misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size 11; this SHALL go to DONE with error set and no bus request.
REQ-020 REQ: bus_req_valid=1 with stable payload; SHALL move to RSP on the bus_req_valid & bus_req_ready edge.
REQ-021 bus_addr SHALL equal the captured address with [1:0] forced to 0.
REQ-022 wstrb SHALL be byte 0001<<a, half 0011<<a, word 1111, where a=addr[1:0]; wdata SHALL be shifted left by 8*a; bus_wstrb SHALL be 0 for loads.
REQ-023 RSP: on bus_rsp_valid, SHALL latch bus_rdata>>(8*a) and bus_rsp_err, then enter DONE.
REQ-024 Load extension SHALL sign-extend from bit 7 or 15 when alu_op[2]=0, and zero-extend otherwise; a word load SHALL be unmodified.
REQ-025 DONE: for exactly one cycle, SHALL assert lsu_exu_rvalid (load) or lsu_exu_wready (store), lsu_err_o if an error was latched, and lsu_rdata (0 for stores or errors); then SHALL return to IDLE.
REQ-026 lsu_rdata SHALL hold its value until the next DONE.
REQ-027 Minimum latency SHALL be 3 cycles from capture to done pulse (bus ready and response each in one cycle); a misaligned access SHALL take 1 cycle.
REQ-028 Request acceptance in DONE SHALL be ignored; lsu_avalid is re-sampled only in IDLE.
REQ-029 bus_rsp_valid seen outside RSP SHALL be dropped without state change.
REQ-030 bus_req_valid SHALL never deassert in REQ before the handshake.
REQ-031 At most one bus transaction SHALL be outstanding.

Reset
REQ-032 rst=0 at a clock edge SHALL force IDLE.
REQ-033 Reset SHALL clear bus_req_valid, lsu_exu_rvalid, lsu_exu_wready, lsu_err_o, and lsu_rdata to 0, regardless of state, including mid-REQ and mid-RSP.
REQ-034 A response arriving after reset SHALL be ignored.

Verification
REQ-035 Load byte, addr 0x8000_0003, alu_op 0000, bus_rdata 0x80FF_1234 -> bus_addr 0x8000_0000, wstrb 0000, lsu_rdata 0xFFFF_FF80, rvalid one cycle.
REQ-036 Load half unsigned, addr 0x...2, alu_op 0101, bus_rdata 0x9ABC_0000 -> lsu_rdata 0x0000_9ABC.
REQ-037 Store half, addr 0x...2, wdata 0x0000_BEEF, with bus_req_ready delayed 3 cycles -> payload stable for those 3 cycles, wdata 0xBEEF_0000, wstrb 1100; wready pulses one cycle after the response.
REQ-038 Word load to addr 0x...1 -> no bus_req_valid; rvalid and lsu_err_o pulse on the next cycle; lsu_rdata 0.
REQ-039 Reset pulse during RSP, then stray bus_rsp_valid -> outputs 0, FSM IDLE, no done pulse.
REQ-040 bus_rsp_err=1 on a store -> wready and lsu_err_o asserted together for one cycle.
